// File: rtl/cmp_arbiter.sv
// -----------------------------------------------------------------------------
// cmp_arbiter
//
// Round-robin arbiter and sequencer for one shared, registered 3-flag
// comparator (zero / equal / greater). Requesters present operand pairs with
// a request level. The arbiter picks one, drives the comparator for one cycle,
// captures the flags one cycle later and returns them with a one-hot Done
// pulse to the requester that owned the transaction.
//
// Ports
//   Clk       clock, all state updates on the rising edge
//   reset     asynchronous, active-high reset
//   Req       [N]    per-requester request level
//   ReqA      [N*W]  packed operand A, requester i at [i*W +: W]
//   ReqB      [N*W]  packed operand B, same packing
//   Grant     [N]    one-cycle one-hot pulse: operands of that requester taken
//   Done      [N]    one-cycle one-hot pulse: Result is valid for that requester
//   Result    [3]    {A==0, A==B, A>B}, held until the next Done
//   Busy             high whenever the sequencer is not idle
//   CmpA/CmpB [W]    comparator operands (always the latched operands)
//   CmpEn            comparator enable, high only while issuing
//   CmpOut    [3]    comparator flags, valid the cycle after CmpEn
//   DbgState  [2]    current sequencer state (0 IDLE, 1 ISSUE, 2 CAPTURE)
//
// Handshake: a requester raises Req with its operands stable and keeps them
// stable until it sees its Grant bit. Grant is the acceptance strobe; the
// requester must drop Req by the clock edge that ends the Grant cycle, and a
// Req still high after that edge is treated as a fresh request. Done is a
// single-cycle strobe with no back-pressure; Result stays valid after it.
// -----------------------------------------------------------------------------
module cmp_arbiter #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic           Clk,
  input  logic           reset,
  input  logic [N-1:0]   Req,
  input  logic [N*W-1:0] ReqA,
  input  logic [N*W-1:0] ReqB,
  output logic [N-1:0]   Grant,
  output logic [N-1:0]   Done,
  output logic [2:0]     Result,
  output logic           Busy,
  output logic [W-1:0]   CmpA,
  output logic [W-1:0]   CmpB,
  output logic           CmpEn,
  input  logic [2:0]     CmpOut,
  output logic [1:0]     DbgState
);

  localparam int PW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [W-1:0]  op_a, op_b;

  // Unpacked views of the operand buses.
  logic [W-1:0] a_arr [N];
  logic [W-1:0] b_arr [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign a_arr[g] = ReqA[g*W +: W];
    assign b_arr[g] = ReqB[g*W +: W];
  end

  // Round-robin search starting at ptr. The loop walks offsets from the far
  // end down to zero so that the smallest offset with a request is the last
  // assignment and therefore wins.
  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [PW:0]   sum;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      if (Req[sum[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[PW-1:0];
      end
    end
  end

  // Next-state and strobe decisions.
  logic do_grant;
  logic do_done;

  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    do_done    = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          do_grant   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = CAPTURE;
      end
      CAPTURE: begin
        // Flags for the current owner are captured here; a new grant can be
        // issued on the same edge so the comparator is never left idle.
        do_done = 1'b1;
        if (win_found) begin
          do_grant   = 1'b1;
          state_next = ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      ptr    <= '0;
      owner  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      Grant  <= '0;
      Done   <= '0;
      Result <= 3'b000;
    end else begin
      Grant <= do_grant ? (N'(1) << win_idx) : '0;
      Done  <= do_done  ? (N'(1) << owner)   : '0;
      if (do_done) begin
        Result <= CmpOut;
      end
      if (do_grant) begin
        owner <= win_idx;
        op_a  <= a_arr[win_idx];
        op_b  <= b_arr[win_idx];
        ptr   <= (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  assign CmpA     = op_a;
  assign CmpB     = op_b;
  assign CmpEn    = (state == ISSUE);
  assign Busy     = (state != IDLE);
  assign DbgState = state;

endmodule

// File: tb/tb_cmp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cmp_arbiter
//
// Directed bench for cmp_arbiter. A behavioural registered comparator closes
// the loop on CmpA/CmpB/CmpEn -> CmpOut. Expected Done/Result pairs are queued
// ahead of time and popped by a monitor whenever Done fires; grant order,
// enable timing, state and reset behaviour are checked inline.
// -----------------------------------------------------------------------------
module tb_cmp_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [N-1:0]   req = '0;
  logic [W-1:0]   tb_a [N];
  logic [W-1:0]   tb_b [N];
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   grant, done;
  logic [2:0]     result;
  logic           busy;
  logic [W-1:0]   cmp_a, cmp_b;
  logic           cmp_en;
  logic [2:0]     cmp_out = 3'b000;
  logic [1:0]     dbg_state;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = tb_a[i];
      req_b[i*W +: W] = tb_b[i];
    end
  end

  cmp_arbiter #(.W(W), .N(N)) dut (
    .Clk      (clk),
    .reset    (rst),
    .Req      (req),
    .ReqA     (req_a),
    .ReqB     (req_b),
    .Grant    (grant),
    .Done     (done),
    .Result   (result),
    .Busy     (busy),
    .CmpA     (cmp_a),
    .CmpB     (cmp_b),
    .CmpEn    (cmp_en),
    .CmpOut   (cmp_out),
    .DbgState (dbg_state)
  );

  // Shared registered comparator.
  always_ff @(posedge clk) begin
    if (cmp_en) begin
      cmp_out <= {cmp_a == '0, cmp_a == cmp_b, cmp_a > cmp_b};
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: {Done one-hot, Result} per expected completion.
  logic [N+2:0] exp_q[$];

  always @(negedge clk) begin
    if (done !== '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'({done, result}), 32'd0);
      end else begin
        check("done_result", 32'({done, result}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Called on the negedge just after the grant edge. Leaves the bench on the
  // CAPTURE-cycle negedge.
  task automatic expect_grant(input logic [N-1:0] mask, input logic [N-1:0] clr);
    check("grant", 32'(grant), 32'(mask));
    check("cmpen_issue", 32'(cmp_en), 32'd1);
    check("state_issue", 32'(dbg_state), 32'd1);
    req = req & ~clr;
    step();
    check("grant_pulse", 32'(grant), 32'd0);
    check("cmpen_capture", 32'(cmp_en), 32'd0);
    check("state_capture", 32'(dbg_state), 32'd2);
  endtask

  task automatic single_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2:0] res);
    logic [N-1:0] m;
    m = N'(1) << idx;
    tb_a[idx] = a;
    tb_b[idx] = b;
    exp_q.push_back({m, res});
    req = m;
    step();
    expect_grant(m, m);
    step();
    check("busy_after", 32'(busy), 32'd0);
    check("result_single", 32'(result), 32'(res));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (total=%0d)", total);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < N; i++) begin
      tb_a[i] = '0;
      tb_b[i] = '0;
    end

    // Reset state.
    step();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmpen", 32'(cmp_en), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    step();
    check("idle_busy", 32'(busy), 32'd0);

    // Single request on requester 1: 5 vs 3 -> greater.
    tb_a[1] = 8'd5;
    tb_b[1] = 8'd3;
    exp_q.push_back({4'b0010, 3'b001});
    req = 4'b0010;
    step();
    expect_grant(4'b0010, 4'b0010);
    check("single_no_early_done", 32'(done), 32'd0);
    step();
    check("single_busy", 32'(busy), 32'd0);
    step();
    check("single_done_pulse", 32'(done), 32'd0);
    check("single_result_hold", 32'(result), 32'b001);

    // All four from reset: grants 0,1,2,3 every two cycles.
    apply_reset();
    tb_a[0] = 8'd0;  tb_b[0] = 8'd0;
    tb_a[1] = 8'd7;  tb_b[1] = 8'd7;
    tb_a[2] = 8'd9;  tb_b[2] = 8'd2;
    tb_a[3] = 8'd1;  tb_b[3] = 8'd200;
    exp_q.push_back({4'b0001, 3'b110});
    exp_q.push_back({4'b0010, 3'b010});
    exp_q.push_back({4'b0100, 3'b001});
    exp_q.push_back({4'b1000, 3'b000});
    req = 4'b1111;
    for (int k = 0; k < N; k++) begin
      logic [N-1:0] m;
      m = N'(1) << k;
      step();
      expect_grant(m, m);
    end
    step();
    check("all4_busy", 32'(busy), 32'd0);

    // Fairness: serve 2 (pointer moves to 3), then 0 and 2 request together
    // with requester 0 holding its request across its own grant.
    single_req(2, 8'd9, 8'd2, 3'b001);
    tb_a[0] = 8'd4;  tb_b[0] = 8'd4;
    tb_a[2] = 8'd3;  tb_b[2] = 8'd9;
    exp_q.push_back({4'b0001, 3'b010});
    exp_q.push_back({4'b0100, 3'b000});
    exp_q.push_back({4'b0001, 3'b010});
    req = 4'b0101;
    step();
    expect_grant(4'b0001, 4'b0000);
    step();
    expect_grant(4'b0100, 4'b0100);
    step();
    expect_grant(4'b0001, 4'b0001);
    step();
    check("fair_busy", 32'(busy), 32'd0);

    // Boundary operands.
    single_req(3, 8'd255, 8'd0,   3'b001);
    single_req(3, 8'd0,   8'd255, 3'b100);
    single_req(3, 8'd255, 8'd255, 3'b010);
    single_req(3, 8'd0,   8'd0,   3'b110);

    // Back-to-back: requester 1 rises while requester 0 is in CAPTURE.
    tb_a[0] = 8'd2;  tb_b[0] = 8'd1;
    exp_q.push_back({4'b0001, 3'b001});
    req = 4'b0001;
    step();
    expect_grant(4'b0001, 4'b0001);
    tb_a[1] = 8'd6;  tb_b[1] = 8'd6;
    exp_q.push_back({4'b0010, 3'b010});
    req = 4'b0010;
    step();
    check("b2b_grant", 32'(grant), 32'b0010);
    check("b2b_done", 32'(done), 32'b0001);
    check("b2b_cmpen", 32'(cmp_en), 32'd1);
    req = 4'b0000;
    step();
    step();
    check("b2b_busy", 32'(busy), 32'd0);
    check("b2b_result", 32'(result), 32'b010);

    // Asynchronous reset in the middle of ISSUE.
    tb_a[2] = 8'd1;  tb_b[2] = 8'd1;
    req = 4'b0100;
    step();
    check("mid_grant", 32'(grant), 32'b0100);
    check("mid_cmpen", 32'(cmp_en), 32'd1);
    req = 4'b0000;
    #2;
    rst = 1'b1;
    #1;
    check("arst_cmpen", 32'(cmp_en), 32'd0);
    check("arst_grant", 32'(grant), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    step();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_result", 32'(result), 32'd0);

    // Pointer restarts at 0: requester 1 wins over 3.
    tb_a[1] = 8'd0;  tb_b[1] = 8'd5;
    tb_a[3] = 8'd8;  tb_b[3] = 8'd8;
    exp_q.push_back({4'b0010, 3'b100});
    exp_q.push_back({4'b1000, 3'b010});
    req = 4'b1010;
    step();
    expect_grant(4'b0010, 4'b0010);
    step();
    expect_grant(4'b1000, 4'b1000);
    step();
    check("final_busy", 32'(busy), 32'd0);
    step();
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
